// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and data requesters onto one single-outstanding memory port
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_ready_o,
    output logic              i_valid_o,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic              d_we_i,
    input  logic [1:0]        d_size_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ready_o,
    output logic              d_valid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              m_req_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic              m_we_o,
    output logic [1:0]        m_size_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic              m_ready_i,
    input  logic              m_rvalid_i,
    input  logic [DATA_W-1:0] m_rdata_i
);
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t        r_state;
    logic          r_owner_d;
    logic [SW-1:0] r_streak;

    logic w_idle;
    logic w_streak_full;
    logic w_grant_d;
    logic w_grant_i;

    // Grants depend only on the requests and the current state; gated by reset so outputs are quiet.
    assign w_idle        = (r_state == S_IDLE) && reset_ni;
    assign w_streak_full = (r_streak == SW'(MAX_D_STREAK));
    assign w_grant_d     = w_idle && d_req_i && !(i_req_i && w_streak_full);
    assign w_grant_i     = w_idle && i_req_i && !w_grant_d;
    assign i_ready_o     = w_grant_i;
    assign d_ready_o     = w_grant_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state   <= S_IDLE;
            r_owner_d <= 1'b0;
            r_streak  <= '0;
            i_valid_o <= 1'b0;
            i_rdata_o <= '0;
            d_valid_o <= 1'b0;
            d_rdata_o <= '0;
            m_req_o   <= 1'b0;
            m_addr_o  <= '0;
            m_we_o    <= 1'b0;
            m_size_o  <= '0;
            m_wdata_o <= '0;
        end else begin
            i_valid_o <= 1'b0;
            d_valid_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_owner_d <= 1'b1;
                        m_addr_o  <= d_addr_i;
                        m_we_o    <= d_we_i;
                        m_size_o  <= d_size_i;
                        m_wdata_o <= d_wdata_i;
                        m_req_o   <= 1'b1;
                        r_state   <= S_REQ;
                        // Streak only counts data grants that made a waiting fetch wait longer.
                        if (!i_req_i)
                            r_streak <= '0;
                        else if (!w_streak_full)
                            r_streak <= r_streak + SW'(1);
                    end else if (w_grant_i) begin
                        r_owner_d <= 1'b0;
                        m_addr_o  <= i_addr_i;
                        m_we_o    <= 1'b0;
                        m_size_o  <= SIZE_WORD;
                        m_wdata_o <= '0;
                        m_req_o   <= 1'b1;
                        r_state   <= S_REQ;
                        r_streak  <= '0;
                    end
                end
                S_REQ: begin
                    if (m_ready_i) begin
                        m_req_o <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (m_rvalid_i) begin
                        if (r_owner_d) begin
                            d_rdata_o <= m_rdata_i;
                            d_valid_o <= 1'b1;
                        end else begin
                            i_rdata_o <= m_rdata_i;
                            i_valid_o <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
